// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit:
// funct3 codes, FSM state encoding and the word-result sign extension helper.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns 64 bits; callers keep the low XLEN bits, so it serves XLEN=32 too.
   function automatic logic [63:0] sext32(input logic [31:0] value);
      return {{32{value[31]}}, value};
   endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand preparation: width select, extension, magnitudes,
// result negate flags and divide special-case detection.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int ENABLE_W = 1
) (
   input  logic [2:0]      funct3,
   input  logic            word,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            word_eff,
   output logic            illegal,
   output logic [XLEN-1:0] mag_a,
   output logic [XLEN-1:0] mag_b,
   output logic            neg_res,
   output logic            neg_rem,
   output logic            div_zero,
   output logic            overflow,
   output logic [XLEN-1:0] dividend
);

   logic            is_div;
   logic            a_signed;
   logic            b_signed;
   logic            a_neg;
   logic            b_neg;
   logic            a_min;
   logic            b_ones;
   logic            b_zero;
   logic [63:0]     a_sx;
   logic [63:0]     a_zx;
   logic [63:0]     b_sx;
   logic [63:0]     b_zx;
   logic [XLEN-1:0] a_w;
   logic [XLEN-1:0] b_w;

   always_comb begin
      word_eff = word && (ENABLE_W != 0) && (XLEN == 64);
      is_div   = funct3[2];
      illegal  = word_eff && (funct3 inside {F3_MULH, F3_MULHSU, F3_MULHU});
      a_signed = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
      b_signed = funct3 inside {F3_MULH, F3_DIV, F3_REM};

      a_sx = sext32(rs1[31:0]);
      a_zx = {32'd0, rs1[31:0]};
      b_sx = sext32(rs2[31:0]);
      b_zx = {32'd0, rs2[31:0]};

      if (word_eff) begin
         a_w      = a_signed ? a_sx[XLEN-1:0] : a_zx[XLEN-1:0];
         b_w      = b_signed ? b_sx[XLEN-1:0] : b_zx[XLEN-1:0];
         a_neg    = a_signed && rs1[31];
         b_neg    = b_signed && rs2[31];
         a_min    = (rs1[31:0] == 32'h8000_0000);
         b_ones   = (rs2[31:0] == 32'hFFFF_FFFF);
         b_zero   = (rs2[31:0] == 32'd0);
         dividend = a_sx[XLEN-1:0];
      end else begin
         a_w      = rs1;
         b_w      = rs2;
         a_neg    = a_signed && rs1[XLEN-1];
         b_neg    = b_signed && rs2[XLEN-1];
         a_min    = (rs1 == {1'b1, {(XLEN-1){1'b0}}});
         b_ones   = &rs2;
         b_zero   = (rs2 == '0);
         dividend = rs1;
      end

      // Magnitudes stay correct for the most-negative value: it negates to itself
      // and reads back as the unsigned 2^(N-1).
      mag_a = a_neg ? -a_w : a_w;
      mag_b = b_neg ? -b_w : b_w;

      neg_res  = a_neg ^ b_neg;
      neg_rem  = a_neg;
      div_zero = is_div && b_zero;
      overflow = is_div && !funct3[0] && a_min && b_ones;
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV64M/RV32M multiply/divide unit: one result bit per cycle,
// valid/ready on both sides, early completion for divide special cases.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int ENABLE_W = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output state_t          dbg_state
);

   // Handshake: a request transfers on a clock edge where valid_i && ready_o && !flush_i;
   // a result transfers on an edge where valid_o && ready_i (a simultaneous flush still
   // counts as delivered). ready_o is high only in IDLE, valid_o only in DONE.

   localparam int CW = $clog2(XLEN);

   state_t            state, state_n;
   logic [CW-1:0]     count, count_n;
   logic [2:0]        funct3_q, funct3_n;
   logic              word_q, word_n;
   logic              neg_res_q, neg_res_n;
   logic              neg_rem_q, neg_rem_n;
   logic [XLEN-1:0]   mag_a_q, mag_a_n;
   logic [XLEN-1:0]   mag_b_q, mag_b_n;
   logic [2*XLEN-1:0] acc, acc_n;
   logic [XLEN-1:0]   result_n;

   logic              p_word;
   logic              p_illegal;
   logic              p_neg_res;
   logic              p_neg_rem;
   logic              p_div_zero;
   logic              p_overflow;
   logic [XLEN-1:0]   p_mag_a;
   logic [XLEN-1:0]   p_mag_b;
   logic [XLEN-1:0]   p_dividend;
   logic [XLEN-1:0]   special_res;

   logic [2*XLEN-1:0] mul_acc;
   logic [2*XLEN-1:0] div_acc;
   logic [2*XLEN-1:0] step_acc;
   logic [2*XLEN-1:0] signed_prod;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   raw_res;
   logic [XLEN-1:0]   final_res;
   logic [63:0]       res_sx;

   muldiv_operand_prep #(
      .XLEN     (XLEN),
      .ENABLE_W (ENABLE_W)
   ) u_prep (
      .funct3   (funct3_i),
      .word     (word_i),
      .rs1      (rs1_i),
      .rs2      (rs2_i),
      .word_eff (p_word),
      .illegal  (p_illegal),
      .mag_a    (p_mag_a),
      .mag_b    (p_mag_b),
      .neg_res  (p_neg_res),
      .neg_rem  (p_neg_rem),
      .div_zero (p_div_zero),
      .overflow (p_overflow),
      .dividend (p_dividend)
   );

   assign ready_o   = (state == IDLE);
   assign valid_o   = (state == DONE);
   assign dbg_state = state;

   // MSB-first iteration indexed by count, so word ops simply start at bit 31.
   // Multiply: acc = 2*acc + (b[count] ? a : 0). Divide: acc = {remainder, quotient}.
   always_comb begin
      mul_acc  = {acc[2*XLEN-2:0], 1'b0} + (mag_b_q[count] ? {{XLEN{1'b0}}, mag_a_q} : '0);
      rem_sh   = {acc[2*XLEN-1:XLEN], mag_a_q[count]};
      diff     = rem_sh - {1'b0, mag_b_q};
      if (diff[XLEN]) begin
         div_acc = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         div_acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
      step_acc = funct3_q[2] ? div_acc : mul_acc;

      signed_prod = neg_res_q ? -step_acc : step_acc;
      quo_s       = neg_res_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
      rem_s       = neg_rem_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

      case (funct3_q)
         F3_MUL:                       raw_res = signed_prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: raw_res = signed_prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              raw_res = quo_s;
         default:                      raw_res = rem_s;
      endcase
      res_sx    = sext32(raw_res[31:0]);
      final_res = word_q ? res_sx[XLEN-1:0] : raw_res;
   end

   always_comb begin
      if (p_illegal) begin
         special_res = '0;
      end else if (p_div_zero) begin
         special_res = funct3_i[1] ? p_dividend : '1;
      end else begin
         special_res = funct3_i[1] ? '0 : p_dividend;
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      funct3_n  = funct3_q;
      word_n    = word_q;
      neg_res_n = neg_res_q;
      neg_rem_n = neg_rem_q;
      mag_a_n   = mag_a_q;
      mag_b_n   = mag_b_q;
      acc_n     = acc;
      result_n  = result_o;

      case (state)
         IDLE: begin
            if (valid_i && !flush_i) begin
               funct3_n  = funct3_i;
               word_n    = p_word;
               neg_res_n = p_neg_res;
               neg_rem_n = p_neg_rem;
               mag_a_n   = p_mag_a;
               mag_b_n   = p_mag_b;
               acc_n     = '0;
               count_n   = p_word ? CW'(31) : CW'(XLEN-1);
               if (p_illegal || p_div_zero || p_overflow) begin
                  result_n = special_res;
                  state_n  = DONE;
               end else begin
                  state_n  = CALC;
               end
            end
         end
         CALC: begin
            if (flush_i) begin
               state_n = IDLE;
            end else begin
               acc_n   = step_acc;
               count_n = count - 1'b1;
               if (count == '0) begin
                  result_n = final_res;
                  state_n  = DONE;
               end
            end
         end
         DONE: begin
            if (ready_i || flush_i) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         funct3_q  <= '0;
         word_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         acc       <= '0;
         result_o  <= '0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         funct3_q  <= funct3_n;
         word_q    <= word_n;
         neg_res_q <= neg_res_n;
         neg_rem_q <= neg_rem_n;
         mag_a_q   <= mag_a_n;
         mag_b_q   <= mag_b_n;
         acc       <= acc_n;
         result_o  <= result_n;
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: arithmetic reference model, per-cycle result
// compare against an expected queue, latency/handshake/flush/reset checks.
module tb_muldiv_iter;
   import muldiv_pkg::*;

   localparam int XLEN = 64;

   logic            clk;
   logic            rst_n;
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      funct3_i;
   logic            word_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   state_t          dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [XLEN-1:0] exp_q[$];

   muldiv_iter #(.XLEN(XLEN), .ENABLE_W(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .funct3_i  (funct3_i),
      .word_i    (word_i),
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .flush_i   (flush_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .result_o  (result_o),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model straight from the RISC-V M-extension rules.
   function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] wa;
      logic signed [127:0] wb;
      logic signed [127:0] prod;
      logic signed [63:0]  sa;
      logic signed [63:0]  sb;
      logic signed [31:0]  sa32;
      logic signed [31:0]  sb32;
      logic [31:0]         r32;
      logic [63:0]         r;
      logic                zero;
      logic                ovf;
      sa   = a;
      sb   = b;
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (w) begin
         zero = (b[31:0] == 32'd0);
         ovf  = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
         case (f3)
            3'd0:    r32 = a[31:0] * b[31:0];
            3'd4:    r32 = zero ? 32'hFFFF_FFFF : (ovf ? a[31:0] : 32'(sa32 / sb32));
            3'd5:    r32 = zero ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
            3'd6:    r32 = zero ? a[31:0] : (ovf ? 32'd0 : 32'(sa32 % sb32));
            3'd7:    r32 = zero ? a[31:0] : a[31:0] % b[31:0];
            default: r32 = 32'd0;
         endcase
         r = {{32{r32[31]}}, r32};
         return r;
      end
      zero = (b == 64'd0);
      ovf  = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      wa   = (f3 == 3'd1 || f3 == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
      wb   = (f3 == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
      prod = wa * wb;
      case (f3)
         3'd0:          r = prod[63:0];
         3'd1, 3'd2, 3'd3: r = prod[127:64];
         3'd4:          r = zero ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(sa / sb));
         3'd5:          r = zero ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
         3'd6:          r = zero ? a : (ovf ? 64'd0 : 64'(sa % sb));
         default:       r = zero ? a : a % b;
      endcase
      return r;
   endfunction

   // ---------------- scoreboard compare (every cycle valid_o is high) ----------------
   always @(negedge clk) begin
      if (rst_n && valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'(valid_o), 64'd0);
         end else begin
            check("result", result_o, exp_q[0]);
            if (ready_i || flush_i) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int lat,
                         input logic [63:0] lit, input bit use_lit);
      logic [63:0] m;
      int cyc;
      m = model(f3, w, a, b);
      if (use_lit) check({name, "_model"}, m, lit);
      @(posedge clk); #1;
      check({name, "_ready"}, 64'(ready_o), 64'd1);
      funct3_i = f3; word_i = w; rs1_i = a; rs2_i = b;
      valid_i  = 1'b1; ready_i = 1'b1;
      exp_q.push_back(m);
      @(posedge clk); #1;
      valid_i = 1'b0;
      cyc = 1;
      while (!valid_o && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, "_latency"}, 64'(cyc), 64'(lat));
      if (!valid_o) exp_q.delete();
      @(posedge clk); #1;
      check({name, "_released"}, 64'(valid_o), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      bit saw_valid;
      rst_n = 1'b0; valid_i = 1'b0; funct3_i = '0; word_i = 1'b0;
      rs1_i = '0; rs2_i = '0; flush_i = 1'b0; ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_result", result_o, 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      rst_n = 1'b1;

      run_op("mul",    F3_MUL,   1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
      run_op("mulhu",  F3_MULHU, 1'b0, '1, '1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      run_op("mulh",   F3_MULH,  1'b0, '1, '1, 65, 64'd0, 1'b1);
      run_op("mulhsu", F3_MULHSU,1'b0, '1, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_op("mulw",   F3_MUL,   1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      run_op("div0",   F3_DIV,   1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_op("remu0",  F3_REMU,  1'b0, 64'd5, 64'd0, 1, 64'd5, 1'b1);
      run_op("divw0",  F3_DIV,   1'b1, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_op("div_ovf",F3_DIV,   1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, 1'b1);
      run_op("rem_ovf",F3_REM,   1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'd0, 1'b1);
      run_op("divw_ovf",F3_DIV,  1'b1, 64'h8000_0000, '1, 1, 64'hFFFF_FFFF_8000_0000, 1'b1);
      run_op("divw",   F3_DIV,   1'b1, 64'h0000_0001_FFFF_FFF8, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      run_op("remw",   F3_REM,   1'b1, 64'h0000_0001_FFFF_FFF8, 64'd3, 33, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      run_op("divuw",  F3_DIVU,  1'b1, 64'hFFFF_FFF8, 64'd3, 33, 64'h0000_0000_5555_5552, 1'b1);
      run_op("remuw",  F3_REMU,  1'b1, 64'hFFFF_FFF8, 64'd3, 33, 64'd2, 1'b1);
      run_op("div_neg",F3_DIV,   1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
      run_op("rem_neg",F3_REM,   1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_op("illegal",F3_MULH,  1'b1, 64'd9, 64'd9, 1, 64'd0, 1'b1);
      run_op("divu_big",F3_DIVU, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0123_4567, 65, 64'd0, 1'b0);

      // Backpressure: DIVU 100/7 held in DONE for 10 cycles
      @(posedge clk); #1;
      funct3_i = F3_DIVU; word_i = 1'b0; rs1_i = 64'd100; rs2_i = 64'd7;
      valid_i = 1'b1; ready_i = 1'b0;
      exp_q.push_back(model(F3_DIVU, 1'b0, 64'd100, 64'd7));
      check("bp_model", model(F3_DIVU, 1'b0, 64'd100, 64'd7), 64'd14);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check("bp_ready_calc", 64'(ready_o), 64'd0);
      cyc = 1;
      while (!valid_o && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("bp_latency", 64'(cyc), 64'd65);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid_hold", 64'(valid_o), 64'd1);
         check("bp_ready_hold", 64'(ready_o), 64'd0);
         check("bp_result_hold", result_o, 64'd14);
         @(posedge clk); #1;
      end
      ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp_ready_after", 64'(ready_o), 64'd1);
      check("bp_valid_after", 64'(valid_o), 64'd0);

      // Flush in CALC cycle 20 of a MUL
      funct3_i = F3_MUL; word_i = 1'b0; rs1_i = 64'd123; rs2_i = 64'd456;
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("flush_in_calc", 64'(dbg_state), 64'(CALC));
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("flush_ready", 64'(ready_o), 64'd1);
      check("flush_valid", 64'(valid_o), 64'd0);
      saw_valid = 1'b0;
      repeat (70) begin
         @(posedge clk); #1;
         if (valid_o) saw_valid = 1'b1;
      end
      check("flush_no_valid", 64'(saw_valid), 64'd0);

      // Async reset pulse mid-CALC (result_o currently holds 14)
      funct3_i = F3_DIVU; rs1_i = 64'd1000; rs2_i = 64'd3;
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      check("pre_rst_result", result_o, 64'd14);
      rst_n = 1'b0;
      #1;
      check("arst_state", 64'(dbg_state), 64'(IDLE));
      check("arst_valid", 64'(valid_o), 64'd0);
      check("arst_ready", 64'(ready_o), 64'd1);
      check("arst_result", result_o, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_rst", F3_DIVU, 1'b0, 64'd1000, 64'd3, 65, 64'd333, 1'b1);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
